// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file -- machine-mode CSR register file for the RV32I core.
//
// Responds to the decoder's CSR controls (read/write enable, write op, source
// select). Holds mstatus (MIE/MPIE), mie, mtvec, mscratch, mepc, mcause, mtval,
// and the 64-bit mcycle/minstret counters. It performs CSRRW/CSRRS/CSRRC
// read-modify-write, captures trap state and handles MRET.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   csr_read_in           decoded CSR read request
//   csr_write_in          decoded CSR write request
//   csr_write_op_in[1:0]  0=RW, 1=RS, 2=RC, 3=reserved (illegal)
//   csr_src_in            0=rs1_data_in, 1=zero-extended zimm_in
//   csr_addr_in[11:0]     CSR address
//   rs1_data_in[31:0]     rs1 operand
//   zimm_in[4:0]          immediate operand
//   retire_in             one instruction retired this cycle
//   trap_in               take trap this cycle (pc/cause/val alongside)
//   mret_in               MRET executing
//   irq_ext/timer/sw_in   level interrupt lines, visible through mip
//   rdata_out             combinational read data (0 when not reading/illegal)
//   illegal_out           access is illegal
//   trap_vector_out       mtvec
//   epc_out               mepc
//   irq_pending_out       globally enabled interrupt is pending
// -----------------------------------------------------------------------------
module csr_file #(
  parameter logic [31:0] TRAP_VEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID        = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_read_in,
  input  logic        csr_write_in,
  input  logic [1:0]  csr_write_op_in,
  input  logic        csr_src_in,
  input  logic [11:0] csr_addr_in,
  input  logic [31:0] rs1_data_in,
  input  logic [4:0]  zimm_in,
  input  logic        retire_in,
  input  logic        trap_in,
  input  logic [31:0] trap_pc_in,
  input  logic [31:0] trap_cause_in,
  input  logic [31:0] trap_val_in,
  input  logic        mret_in,
  input  logic        irq_ext_in,
  input  logic        irq_timer_in,
  input  logic        irq_sw_in,
  output logic [31:0] rdata_out,
  output logic        illegal_out,
  output logic [31:0] trap_vector_out,
  output logic [31:0] epc_out,
  output logic        irq_pending_out
);

  typedef enum logic [1:0] {
    OP_RW   = 2'd0,
    OP_RS   = 2'd1,
    OP_RC   = 2'd2,
    OP_RSVD = 2'd3
  } csr_op_e;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
  localparam logic [31:0] ALIGN4    = 32'hFFFF_FFFC;

  // State
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  // Combinational views
  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic [31:0] csr_old;
  logic        addr_mapped;
  logic [31:0] src_val;
  logic [31:0] wdata;
  logic        csr_we;
  csr_op_e     op;

  assign op = csr_op_e'(csr_write_op_in);

  // MPP is hard-wired to machine mode.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mip_val     = {20'b0, irq_ext_in, 3'b0, irq_timer_in, 3'b0, irq_sw_in, 3'b0};

  // Address decode: current value of the addressed CSR plus a hit flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    csr_old     = '0;
    addr_mapped = 1'b1;
    case (csr_addr_in)
      A_MSTATUS:              csr_old = mstatus_val;
      A_MISA:                 csr_old = MISA_VAL;
      A_MIE:                  csr_old = mie_q;
      A_MTVEC:                csr_old = mtvec_q;
      A_MSCRATCH:             csr_old = mscratch_q;
      A_MEPC:                 csr_old = mepc_q;
      A_MCAUSE:               csr_old = mcause_q;
      A_MTVAL:                csr_old = mtval_q;
      A_MIP:                  csr_old = mip_val;
      A_MCYCLE,   A_CYCLE:    csr_old = mcycle_q[31:0];
      A_MCYCLEH,  A_CYCLEH:   csr_old = mcycle_q[63:32];
      A_MINSTRET, A_INSTRET:  csr_old = minstret_q[31:0];
      A_MINSTRETH, A_INSTRETH: csr_old = minstret_q[63:32];
      A_MHARTID:              csr_old = HART_ID;
      default:                addr_mapped = 1'b0;
    endcase
  end

  // Addresses with [11:10]==2'b11 are read-only by encoding.
  assign illegal_out = (csr_read_in | csr_write_in) &
                       (~addr_mapped |
                        (csr_write_in & (csr_addr_in[11:10] == 2'b11)) |
                        (csr_write_in & (op == OP_RSVD)));

  assign rdata_out = (csr_read_in & ~illegal_out) ? csr_old : 32'h0;

  assign src_val = csr_src_in ? {27'b0, zimm_in} : rs1_data_in;

  always_comb begin
    wdata = src_val;
    case (op)
      OP_RS:   wdata = csr_old | src_val;
      OP_RC:   wdata = csr_old & ~src_val;
      default: wdata = src_val;
    endcase
  end

  // Trap and MRET both pre-empt a CSR write issued in the same cycle.
  assign csr_we = csr_write_in & ~illegal_out & ~trap_in & ~mret_in;

  // Next-state logic
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = retire_in ? (minstret_q + 64'd1) : minstret_q;

    if (trap_in) begin
      mepc_d         = trap_pc_in & ALIGN4;
      mcause_d       = trap_cause_in;
      mtval_d        = trap_val_in;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_in) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      // A write to either counter half replaces that half and suppresses the
      // increment of that counter for this cycle.
      case (csr_addr_in)
        A_MSTATUS: begin
          mstatus_mie_d  = wdata[3];
          mstatus_mpie_d = wdata[7];
        end
        A_MIE:       mie_d      = wdata & MIE_MASK;
        A_MTVEC:     mtvec_d    = wdata & ALIGN4;
        A_MSCRATCH:  mscratch_d = wdata;
        A_MEPC:      mepc_d     = wdata & ALIGN4;
        A_MCAUSE:    mcause_d   = wdata;
        A_MTVAL:     mtval_d    = wdata;
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata};
        A_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], wdata};
        A_MINSTRETH: minstret_d = {wdata, minstret_q[31:0]};
        default: ; // misa, mip: writes accepted and ignored
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= TRAP_VEC_RESET & ALIGN4;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge inputs regardless of statement order.
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  assign trap_vector_out = mtvec_q;
  assign epc_out         = mepc_q;
  assign irq_pending_out = mstatus_mie_q & (|(mie_q & mip_val));

endmodule

// File: tb/tb_csr_file.sv
// -----------------------------------------------------------------------------
// tb_csr_file -- directed testbench for csr_file with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_csr_file;

  localparam logic [31:0] TVEC  = 32'h8000_0103;
  localparam logic [31:0] HART  = 32'h0000_0005;

  logic        clk;
  logic        rst_n;
  logic        csr_read_in;
  logic        csr_write_in;
  logic [1:0]  csr_write_op_in;
  logic        csr_src_in;
  logic [11:0] csr_addr_in;
  logic [31:0] rs1_data_in;
  logic [4:0]  zimm_in;
  logic        retire_in;
  logic        trap_in;
  logic [31:0] trap_pc_in;
  logic [31:0] trap_cause_in;
  logic [31:0] trap_val_in;
  logic        mret_in;
  logic        irq_ext_in;
  logic        irq_timer_in;
  logic        irq_sw_in;
  logic [31:0] rdata_out;
  logic        illegal_out;
  logic [31:0] trap_vector_out;
  logic [31:0] epc_out;
  logic        irq_pending_out;

  int n_checks;
  int n_errors;

  csr_file #(.TRAP_VEC_RESET(TVEC), .HART_ID(HART)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_read_in     (csr_read_in),
    .csr_write_in    (csr_write_in),
    .csr_write_op_in (csr_write_op_in),
    .csr_src_in      (csr_src_in),
    .csr_addr_in     (csr_addr_in),
    .rs1_data_in     (rs1_data_in),
    .zimm_in         (zimm_in),
    .retire_in       (retire_in),
    .trap_in         (trap_in),
    .trap_pc_in      (trap_pc_in),
    .trap_cause_in   (trap_cause_in),
    .trap_val_in     (trap_val_in),
    .mret_in         (mret_in),
    .irq_ext_in      (irq_ext_in),
    .irq_timer_in    (irq_timer_in),
    .irq_sw_in       (irq_sw_in),
    .rdata_out       (rdata_out),
    .illegal_out     (illegal_out),
    .trap_vector_out (trap_vector_out),
    .epc_out         (epc_out),
    .irq_pending_out (irq_pending_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // 1 time unit after that, well away from either clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_read_in = 1'b0; csr_write_in = 1'b0; csr_write_op_in = 2'd0;
    csr_src_in = 1'b0; csr_addr_in = 12'h0; rs1_data_in = '0; zimm_in = '0;
    trap_in = 1'b0; mret_in = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr);
    idle();
    csr_read_in = 1'b1;
    csr_addr_in = addr;
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic src,
                    input logic [31:0] rs1, input logic [4:0] zimm);
    idle();
    csr_read_in = 1'b1; csr_write_in = 1'b1; csr_write_op_in = op;
    csr_src_in = src; csr_addr_in = addr; rs1_data_in = rs1; zimm_in = zimm;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle();
    retire_in = 1'b0; trap_pc_in = '0; trap_cause_in = '0; trap_val_in = '0;
    irq_ext_in = 1'b0; irq_timer_in = 1'b0; irq_sw_in = 1'b0;

    // Reset state
    #12;
    check("rst_rdata", rdata_out, 32'h0);
    check("rst_illegal", {31'b0, illegal_out}, 32'h0);
    check("rst_irq", {31'b0, irq_pending_out}, 32'h0);
    check("rst_tvec_out", trap_vector_out, 32'h8000_0100);
    check("rst_epc_out", epc_out, 32'h0);
    #5 rst_n = 1'b1;
    tick();

    rd(12'h301); check("misa", rdata_out, 32'h4000_0100);
    check("misa_legal", {31'b0, illegal_out}, 32'h0);
    rd(12'hF14); check("mhartid", rdata_out, HART);
    rd(12'h305); check("mtvec", rdata_out, 32'h8000_0100);
    rd(12'h300); check("mstatus_rst", rdata_out, 32'h0000_1800);

    // mscratch RW / RS / RC
    wr(12'h340, 2'd0, 1'b0, 32'hDEAD_BEEF, 5'd0);
    check("rw_old", rdata_out, 32'h0);
    tick();
    wr(12'h340, 2'd1, 1'b0, 32'h0000_00F0, 5'd0);
    check("rs_old", rdata_out, 32'hDEAD_BEEF);
    tick();
    rd(12'h340); check("rs_new", rdata_out, 32'hDEAD_BEFF);
    wr(12'h340, 2'd2, 1'b1, 32'hFFFF_FFFF, 5'h0F);
    check("rc_old", rdata_out, 32'hDEAD_BEFF);
    tick();
    rd(12'h340); check("rc_new", rdata_out, 32'hDEAD_BEF0);

    // mtvec low bits masked
    wr(12'h305, 2'd0, 1'b0, 32'h0000_1003, 5'd0);
    tick();
    rd(12'h305); check("mtvec_wr", rdata_out, 32'h0000_1000);
    check("tvec_out", trap_vector_out, 32'h0000_1000);

    // mcycle carry into high half
    wr(12'hB00, 2'd0, 1'b0, 32'hFFFF_FFFF, 5'd0);
    tick();
    wr(12'hB80, 2'd0, 1'b0, 32'h0, 5'd0);
    tick();
    idle();
    tick();
    tick();
    rd(12'hB80); check("mcycleh", rdata_out, 32'h1);
    rd(12'hB00); check("mcycle", rdata_out, 32'h1);
    wr(12'hC00, 2'd0, 1'b0, 32'h0000_0055, 5'd0);
    check("cycle_wr_illegal", {31'b0, illegal_out}, 32'h1);
    check("cycle_wr_rdata", rdata_out, 32'h0);
    tick();
    rd(12'hC00); check("cycle_shadow", rdata_out, 32'h2);
    check("cycle_rd_legal", {31'b0, illegal_out}, 32'h0);

    // minstret counts only retirements
    wr(12'hB02, 2'd0, 1'b0, 32'h0000_0010, 5'd0);
    retire_in = 1'b1;
    tick();
    idle();
    tick();
    tick();
    retire_in = 1'b0;
    tick();
    rd(12'hC02); check("instret", rdata_out, 32'h12);

    // Interrupt enable and pending
    wr(12'h300, 2'd1, 1'b1, 32'h0, 5'h08);
    tick();
    wr(12'h304, 2'd1, 1'b0, 32'hFFFF_FFFF, 5'd0);
    tick();
    rd(12'h304); check("mie_mask", rdata_out, 32'h0000_0888);
    wr(12'h304, 2'd0, 1'b0, 32'h0000_0080, 5'd0);
    tick();
    idle();
    irq_sw_in = 1'b1;
    #1;
    check("irq_sw_masked", {31'b0, irq_pending_out}, 32'h0);
    irq_sw_in = 1'b0;
    irq_timer_in = 1'b1;
    #1;
    check("irq_pending", {31'b0, irq_pending_out}, 32'h1);
    rd(12'h344); check("mip", rdata_out, 32'h0000_0080);

    // Trap wins over a same-cycle mscratch write
    wr(12'h340, 2'd0, 1'b0, 32'h0000_1234, 5'd0);
    trap_in = 1'b1; trap_pc_in = 32'h0000_0104;
    trap_cause_in = 32'h8000_0007; trap_val_in = 32'h0000_00AB;
    #1;
    tick();
    idle();
    #1;
    check("trap_epc_out", epc_out, 32'h0000_0104);
    check("trap_irq", {31'b0, irq_pending_out}, 32'h0);
    rd(12'h342); check("trap_mcause", rdata_out, 32'h8000_0007);
    rd(12'h343); check("trap_mtval", rdata_out, 32'h0000_00AB);
    rd(12'h300); check("trap_mstatus", rdata_out, 32'h0000_1880);
    rd(12'h340); check("trap_mscratch", rdata_out, 32'hDEAD_BEF0);

    // MRET
    idle();
    mret_in = 1'b1;
    tick();
    idle();
    rd(12'h300); check("mret_mstatus", rdata_out, 32'h0000_1888);
    check("mret_irq", {31'b0, irq_pending_out}, 32'h1);

    // Unmapped address and reserved op
    wr(12'h7C0, 2'd0, 1'b0, 32'h1111_1111, 5'd0);
    check("unmapped_illegal", {31'b0, illegal_out}, 32'h1);
    check("unmapped_rdata", rdata_out, 32'h0);
    tick();
    wr(12'h340, 2'd3, 1'b0, 32'h2222_2222, 5'd0);
    check("rsvd_op_illegal", {31'b0, illegal_out}, 32'h1);
    tick();
    rd(12'h340); check("no_change", rdata_out, 32'hDEAD_BEF0);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mscratch", rdata_out, 32'h0);
    check("arst_irq", {31'b0, irq_pending_out}, 32'h0);
    check("arst_tvec", trap_vector_out, 32'h8000_0100);
    check("arst_epc", epc_out, 32'h0);
    csr_addr_in = 12'h300;
    #1;
    check("arst_mstatus", rdata_out, 32'h0000_1800);
    csr_addr_in = 12'hB00;
    #1;
    check("arst_mcycle", rdata_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode CSR register file for the RV32I core. It is the responder to the decoder's CSR control outputs: read enable, write enable, write op and source select. It holds the trap, status and counter CSRs, performs CSRRW/CSRRS/CSRRC read-modify-write, and supplies the trap vector, exception PC and interrupt-pending indication to the pipeline.

Parameters:
TRAP_VEC_RESET, 32'h0000_0000, reset value of mtvec
HART_ID, 32'h0, value returned by mhartid

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
csr_read_in  in  1  decoded CSR read request
csr_write_in  in  1  decoded CSR write request
csr_write_op_in  in  2  0=RW, 1=RS (set), 2=RC (clear), 3=reserved
csr_src_in  in  1  0=rs1 value, 1=zero-extended zimm
csr_addr_in  in  12  CSR address (instr[31:20])
rs1_data_in  in  32  rs1 operand
zimm_in  in  5  immediate operand (instr[19:15])
retire_in  in  1  one instruction retired this cycle
trap_in  in  1  take trap this cycle
trap_pc_in  in  32  PC of trapping instruction
trap_cause_in  in  32  mcause value
trap_val_in  in  32  mtval value
mret_in  in  1  MRET executing
irq_ext_in, irq_timer_in, irq_sw_in  in  1 each  interrupt lines (level)
rdata_out  out  32  CSR read data
illegal_out  out  1  access illegal
trap_vector_out  out  32  mtvec
epc_out  out  32  mepc
irq_pending_out  out  1  enabled interrupt pending

Behaviour:
- Reset (rst_n low, asynchronous): all CSRs and counters 0, except mtvec=TRAP_VEC_RESET with bits[1:0] forced to 0. All outputs derive from state; after reset: rdata_out=0, illegal_out=0, irq_pending_out=0.
- Implemented map:
  - mstatus 0x300: MIE bit3, MPIE bit7 writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: RO, reads 32'h4000_0100.
  - mie 0x304: bits 3,7,11 writable.
  - mtvec 0x305: bits[1:0] read 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342, mtval 0x343: full 32 bits.
  - mip 0x344: RO; bit3=irq_sw_in, bit7=irq_timer_in, bit11=irq_ext_in.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: writable.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82: RO shadows.
  - mhartid 0xF14: RO, reads HART_ID.
- Read: combinational. rdata_out = current value of the addressed CSR when csr_read_in=1, else 0. Reads return the pre-write value; a write lands at the next rising edge.
- Write source: src = csr_src_in ? {27'b0, zimm_in} : rs1_data_in.
- Write value: RW -> src; RS -> old|src; RC -> old&~src. Mask applied after the op. Committed at the rising edge when csr_write_in=1 and illegal_out=0.
- illegal_out (combinational) = (csr_read_in|csr_write_in) & (unmapped address | (csr_write_in & addr[11:10]==2'b11) | (csr_write_in & op==3)). When illegal: no state change, rdata_out=0.
- Counters: 64-bit, wrap to 0 after all-ones.
  - mcycle increments every cycle out of reset.
  - minstret increments when retire_in=1.
  - A CSR write to either half in the same cycle replaces that half with the written value. That counter does not increment that cycle.
- Trap (trap_in=1), at the edge: mepc<=trap_pc_in&~3, mcause<=trap_cause_in, mtval<=trap_val_in, MPIE<=MIE, MIE<=0.
- MRET (mret_in=1, trap_in=0): MIE<=MPIE, MPIE<=1.
- Priority in one cycle: trap > mret > CSR write. A lower-priority action that cycle is dropped entirely. Counter increments still happen.
- irq_pending_out = MIE & |(mie & mip), combinational.

Test Plan:
- Reset then read misa, mhartid, mtvec -> 32'h4000_0100, HART_ID, TRAP_VEC_RESET; illegal_out=0.
- CSRRW mscratch=0xDEAD_BEEF -> same-cycle rdata_out=0. Next CSRRS src=0x0000_00F0 on 0x340 -> reads 0xDEAD_BEEF; later read gives 0xDEAD_BEFF. CSRRC zimm=0x0F -> 0xDEAD_BEF0.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1, mcycle=1. Write 0xC00 -> illegal_out=1, value unchanged.
- Set MIE=1, mie bit7=1, raise irq_timer_in -> irq_pending_out=1. trap_in with pc=0x104, cause=0x8000_0007 in the same cycle as a write to mscratch -> mepc=0x104, mcause set, MIE=0, MPIE=1, mscratch unchanged, irq_pending_out=0.
- mret_in -> MIE=1, MPIE=1.
- Access 0x7C0 -> illegal_out=1, rdata_out=0, no state change. Assert rst_n low mid-stream -> all CSRs immediately at reset values without waiting for a clock edge.
